// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-side signal bundle for the load/store controller.
//
// Handshake: the request is accepted in a cycle where req_valid_i and
// req_ready_o are both high. The requester must hold req_valid_i and the
// request fields stable until then. rsp_valid_o is a one-cycle pulse with no
// backpressure. RAM read data is valid the cycle after ram_r_en_o.
interface lsu_mem_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          ram_w_en_o;
  logic [AW-1:0] ram_w_addr_o;
  logic [DW-1:0] ram_w_data_o;
  logic          ram_r_en_o;
  logic [AW-1:0] ram_r_addr_o;
  logic [DW-1:0] ram_r_data_i;

  // Controller side.
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, ram_r_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_en_o, ram_r_addr_o
  );

  // CPU / RAM environment side.
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, ram_r_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_en_o, ram_r_addr_o
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-wide RAM without byte enables.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended.
// One request in flight at a time.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned requests
// complete immediately with rsp_err_o=1 and no RAM access; when undefined,
// addresses are aligned down to the access size and rsp_err_o is always 0.
module lsu_mem_ctrl #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW+1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
`ifdef MISALIGN_TRAP_EN
  logic          err_q;
`endif
  logic          accept;
  logic          misalign;
  logic [AW+1:0] addr_cap;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] merged;
  logic          unused_addr_hi;

  assign accept         = bus.req_valid_i && (state_q == S_IDLE);
  assign state_dbg      = state_q;
  // Address bits above the RAM window are dropped, so accesses wrap.
  assign unused_addr_hi = ^bus.req_addr_i[31:AW+2];

  // Misalignment detection and the byte address captured on accept.
  always_comb begin
    addr_cap = bus.req_addr_i[AW+1:0];
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (bus.req_size_i[1]) misalign = (bus.req_addr_i[1:0] != 2'b00);
    else if (bus.req_size_i[0]) misalign = bus.req_addr_i[0];
`else
    if (bus.req_size_i[1]) addr_cap[1:0] = 2'b00;
    else if (bus.req_size_i[0]) addr_cap[0] = 1'b0;
`endif
  end

  // Lane select/extend for loads and lane overwrite for sub-word stores.
  always_comb begin
    lane_b = bus.ram_r_data_i[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = bus.ram_r_data_i[15:8];
      2'd2:    lane_b = bus.ram_r_data_i[23:16];
      2'd3:    lane_b = bus.ram_r_data_i[31:24];
      default: lane_b = bus.ram_r_data_i[7:0];
    endcase
    lane_h = addr_q[1] ? bus.ram_r_data_i[31:16] : bus.ram_r_data_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = bus.ram_r_data_i;
    endcase
    merged = bus.ram_r_data_i;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          2'd3:    merged[31:24] = wdata_q[7:0];
          default: merged[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign)                   state_d = S_RESP;
          else if (!bus.req_we_i)         state_d = S_RD;
          else if (bus.req_size_i[1])     state_d = S_WR;
          else                            state_d = S_RD;
        end
      end
      S_RD:    state_d = S_MERGE;
      S_MERGE: state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; buses are zero whenever their enable is low.
  always_comb begin
    bus.req_ready_o  = 1'b0;
    bus.ram_r_en_o   = 1'b0;
    bus.ram_r_addr_o = '0;
    bus.ram_w_en_o   = 1'b0;
    bus.ram_w_addr_o = '0;
    bus.ram_w_data_o = '0;
    bus.rsp_valid_o  = 1'b0;
    bus.rsp_rdata_o  = '0;
    bus.rsp_err_o    = 1'b0;
    case (state_q)
      S_IDLE: bus.req_ready_o = 1'b1;
      S_RD: begin
        bus.ram_r_en_o   = 1'b1;
        bus.ram_r_addr_o = addr_q[AW+1:2];
      end
      S_WR: begin
        bus.ram_w_en_o   = 1'b1;
        bus.ram_w_addr_o = addr_q[AW+1:2];
        bus.ram_w_data_o = wdata_q;
      end
      S_RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_rdata_o = rdata_q;
`ifdef MISALIGN_TRAP_EN
        bus.rsp_err_o   = err_q;
`endif
      end
      default: ;
    endcase
  end

  // Request capture on accept; merge result or load data captured in MERGE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q    <= bus.req_we_i;
        size_q  <= bus.req_size_i;
        uns_q   <= bus.req_unsigned_i;
        addr_q  <= addr_cap;
        wdata_q <= bus.req_wdata_i;
        rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
        err_q   <= misalign;
`endif
      end
      if (state_q == S_MERGE) begin
        if (we_q) wdata_q <= merged;
        else      rdata_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed table, randomized traffic against a
// byte-array reference memory, held-valid and mid-operation reset sequences.
module tb_lsu_mem_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MEM_BYTES = 1 << (AW + 2);

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] state_dbg;
  int n_vec = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic [7:0] ref_mem [0:MEM_BYTES-1] = '{default: '0};
  vec_t tab[$];

  lsu_mem_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  lsu_mem_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Word-wide RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_w_en_o) ram[bus.ram_w_addr_o] <= bus.ram_w_data_o;
    if (bus.ram_r_en_o) bus.ram_r_data_i <= ram[bus.ram_r_addr_o];
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus-idle rules checked every cycle: enables exclusive, idle buses zero.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_bus_rules",
          {29'd0,
           bus.ram_r_en_o && bus.ram_w_en_o,
           (!bus.ram_r_en_o && bus.ram_r_addr_o != '0) ||
           (!bus.ram_w_en_o && (bus.ram_w_addr_o != '0 || bus.ram_w_data_o != '0)),
           !bus.rsp_valid_o && (bus.rsp_rdata_o != '0 || bus.rsp_err_o)},
          32'd0);
    end
  end

  // Reference model: byte-addressed memory, access rules applied directly.
  task automatic ref_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output int lat, output logic err,
                         output int nrd, output int nwr, output logic [AW-1:0] raddr,
                         output logic [AW-1:0] waddr, output logic [31:0] wword);
    int nb;
    int a;
    int w;
    logic [31:0] v;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a = int'(addr & (MEM_BYTES - 1));
    rd = '0; lat = 0; err = 1'b0; nrd = 0; nwr = 0; raddr = '0; waddr = '0; wword = '0;
`ifdef MISALIGN_TRAP_EN
    if ((a % nb) != 0) begin
      lat = 1;
      err = 1'b1;
      return;
    end
`else
    a = a - (a % nb);
`endif
    w = a - (a % 4);
    raddr = AW'(a / 4);
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[a + i] = wdata[8*i +: 8];
      nwr = 1;
      nrd = (nb == 4) ? 0 : 1;
      lat = (nb == 4) ? 2 : 4;
      waddr = AW'(a / 4);
      wword = {ref_mem[w + 3], ref_mem[w + 2], ref_mem[w + 1], ref_mem[w]};
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rd = v;
      lat = 3;
      nrd = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output logic err,
                        output int n_rd, output int n_wr, output logic [AW-1:0] r_addr,
                        output logic [AW-1:0] w_addr, output logic [31:0] w_data);
    int budget;
    rd = '0; lat = 0; err = 1'b0; n_rd = 0; n_wr = 0; r_addr = '0; w_addr = '0; w_data = '0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = we;
    bus.req_size_i = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i = addr;
    bus.req_wdata_i = wdata;
    budget = 0;
    while (!bus.req_ready_o && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready_o) chk("req_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.ram_r_en_o) begin n_rd++; r_addr = bus.ram_r_addr_o; end
      if (bus.ram_w_en_o) begin n_wr++; w_addr = bus.ram_w_addr_o; w_data = bus.ram_w_data_o; end
      if (bus.rsp_valid_o) begin
        lat = c;
        rd = bus.rsp_rdata_o;
        err = bus.rsp_err_o;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  // One transaction checked against the table entry or the reference model.
  task automatic run_vec(input vec_t v, input bit use_tab, input string tag);
    logic [31:0] rd, e_rd, w_data, e_wword;
    int lat, e_lat, n_rd, n_wr, e_nrd, e_nwr;
    logic err, e_err;
    logic [AW-1:0] r_addr, w_addr, e_raddr, e_waddr;
    do_req(v.we, v.size, v.uns, v.addr, v.wdata, rd, lat, err, n_rd, n_wr, r_addr, w_addr, w_data);
    ref_txn(v.we, v.size, v.uns, v.addr, v.wdata, e_rd, e_lat, e_err, e_nrd, e_nwr,
            e_raddr, e_waddr, e_wword);
    if (use_tab) begin
      e_rd = v.exp_rd;
      e_lat = v.exp_lat;
      e_err = v.exp_err;
    end
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    chk({tag, "_n_ram_rd"}, 32'(n_rd), 32'(e_nrd));
    chk({tag, "_n_ram_wr"}, 32'(n_wr), 32'(e_nwr));
    if (e_nrd > 0) chk({tag, "_ram_r_addr"}, 32'(r_addr), 32'(e_raddr));
    if (e_nwr > 0) begin
      chk({tag, "_ram_w_addr"}, 32'(w_addr), 32'(e_waddr));
      chk({tag, "_ram_w_data"}, w_data, e_wword);
    end
  endtask

  task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input int exp_lat, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_err = exp_err;
    tab.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    logic [31:0] e_rd, e_wword, rd2;
    int e_lat, e_nrd, e_nwr, acc2, drop_at, rsp_n, rsp1, rsp2;
    logic e_err;
    logic [AW-1:0] e_raddr, e_waddr;

    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;

    // Directed table: we, size, uns, addr, wdata, expected rdata, latency, err.
    add_vec(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 0);
    add_vec(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 0);
    add_vec(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 2, 0);
    add_vec(1, 2'b00, 0, 32'h21, 32'h000000AA, 32'h0, 4, 0);
    add_vec(0, 2'b10, 0, 32'h20, 32'h0, 32'h1122AA44, 3, 0);
    add_vec(1, 2'b10, 0, 32'h30, 32'h80007F80, 32'h0, 2, 0);
    add_vec(0, 2'b00, 0, 32'h30, 32'h0, 32'hFFFFFF80, 3, 0);
    add_vec(0, 2'b00, 1, 32'h30, 32'h0, 32'h00000080, 3, 0);
    add_vec(0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFF8000, 3, 0);
    add_vec(0, 2'b01, 1, 32'h32, 32'h0, 32'h00008000, 3, 0);
    add_vec(0, 2'b11, 0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 0);
    add_vec(1, 2'b01, 0, 32'h12, 32'h5555CAFE, 32'h0, 4, 0);
    add_vec(0, 2'b10, 0, 32'h10, 32'h0, 32'hCAFEBEEF, 3, 0);
    add_vec(1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 2, 0);
`ifdef MISALIGN_TRAP_EN
    add_vec(0, 2'b10, 0, 32'h4002, 32'h0, 32'h0, 1, 1);
`else
    add_vec(0, 2'b10, 0, 32'h4002, 32'h0, 32'hCAFEF00D, 3, 0);
`endif

    // Reset state.
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
    chk("rst_ram_en", {30'd0, bus.ram_r_en_o, bus.ram_w_en_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < tab.size(); i++) run_vec(tab[i], 1'b1, $sformatf("tab%0d", i));

    // Randomized traffic in a small window so sub-word accesses share words.
    for (int i = 0; i < 300; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.size = 2'($urandom_range(0, 3));
      rv.uns = 1'($urandom_range(0, 1));
      rv.addr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) rv.addr = rv.addr | ($urandom() << (AW + 2));
      rv.wdata = $urandom();
      run_vec(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    // Valid held high through a sub-word store: second accept after RESP.
    rv.we = 1; rv.size = 2'b10; rv.uns = 0; rv.addr = 32'h40; rv.wdata = 32'h01020304;
    run_vec(rv, 1'b0, "t5_init");
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = 1'b1;
    bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h43;
    bus.req_wdata_i = 32'h0000005A;
    chk("t5_ready_at_start", {31'd0, bus.req_ready_o}, 32'd1);
    acc2 = 0; drop_at = 0; rsp_n = 0; rsp1 = 0; rsp2 = 0; rd2 = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_we_i = 1'b0;
        bus.req_size_i = 2'b10;
        bus.req_addr_i = 32'h40;
        bus.req_wdata_i = '0;
      end
      if (drop_at == c) bus.req_valid_i = 1'b0;
      if (bus.rsp_valid_o) begin
        rsp_n++;
        if (rsp_n == 1) rsp1 = c;
        else if (rsp_n == 2) begin rsp2 = c; rd2 = bus.rsp_rdata_o; end
      end
      if (bus.req_ready_o && bus.req_valid_i && acc2 == 0) begin
        acc2 = c;
        drop_at = c + 1;
      end
    end
    ref_txn(1, 2'b00, 0, 32'h43, 32'h5A, e_rd, e_lat, e_err, e_nrd, e_nwr, e_raddr, e_waddr, e_wword);
    ref_txn(0, 2'b10, 0, 32'h40, 32'h0, e_rd, e_lat, e_err, e_nrd, e_nwr, e_raddr, e_waddr, e_wword);
    chk("t5_first_rsp_cycle", 32'(rsp1), 32'd4);
    chk("t5_second_accept_cycle", 32'(acc2), 32'd5);
    chk("t5_second_rsp_cycle", 32'(rsp2), 32'd8);
    chk("t5_rsp_pulses", 32'(rsp_n), 32'd2);
    chk("t5_load_data", rd2, 32'h5A020304);
    chk("t5_load_data_ref", rd2, e_rd);

    // Reset dropped while a byte store sits in MERGE.
    rv.we = 1; rv.size = 2'b10; rv.uns = 0; rv.addr = 32'h50; rv.wdata = 32'h11111111;
    run_vec(rv, 1'b0, "t6_init");
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = 1'b1;
    bus.req_size_i = 2'b00;
    bus.req_addr_i = 32'h50;
    bus.req_wdata_i = 32'h22;
    chk("t6_ready_before", {31'd0, bus.req_ready_o}, 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("t6_rd_cycle_r_en", {31'd0, bus.ram_r_en_o}, 32'd1);
    @(negedge clk);
    chk("t6_merge_no_enables", {30'd0, bus.ram_r_en_o, bus.ram_w_en_o}, 32'd0);
    rst = 1'b0;
    #1;
    if (bus.req_ready_o !== 1'b1)
      $display("t6 note: state_dbg=%0d after reset", state_dbg);
    chk("t6_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("t6_rst_outputs",
        {29'd0, bus.ram_w_en_o, bus.ram_r_en_o, bus.rsp_valid_o}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_in_rst_no_write", {31'd0, bus.ram_w_en_o}, 32'd0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_after_rst_quiet", {30'd0, bus.ram_w_en_o, bus.rsp_valid_o}, 32'd0);
    end
    chk("t6_ram_word_kept", ram[(32'h50 >> 2)], 32'h11111111);
    rv.we = 0; rv.size = 2'b10; rv.uns = 0; rv.addr = 32'h50; rv.wdata = 32'h0;
    run_vec(rv, 1'b0, "t6_reload");

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
